// File: rtl/lc3_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_access
// Brief    : LC3 memory-access stage. Accepts one load/store request from
//            Execute, runs direct or indirect (pointer-then-data) accesses on
//            the data-memory port with a per-strobe timeout, and returns the
//            loaded word to Writeback with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_access #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [1:0]        mem_type,
   input  logic [DATA_W-1:0] M_addr,
   input  logic [DATA_W-1:0] M_data,
   output logic [DATA_W-1:0] Data_addr,
   output logic [DATA_W-1:0] Data_din,
   output logic              Data_rd,
   output logic              Data_req,
   input  logic [DATA_W-1:0] Data_dout,
   input  logic              complete_data,
   output logic [DATA_W-1:0] memout,
   output logic              mem_done,
   output logic              mem_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PTR    = 3'd1;
   localparam logic [2:0] S_GAP    = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int              CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Abort happens on the edge where the stall count would reach TIMEOUT.
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

   logic [2:0]        state_q, state_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              req_q, req_d;
   logic              rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] memout_q, memout_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;

   logic accept;
   logic timeout_hit;

   // req_q is high exactly in PTR and ACCESS, so it also qualifies completion.
   assign accept      = (state_q == S_IDLE) && mem_valid;
   assign timeout_hit = req_q && !complete_data && (cnt_q == CNT_LIM);

   // State and output registers; reset aborts any access immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         req_q    <= 1'b0;
         rd_q     <= 1'b1;
         cnt_q    <= '0;
         memout_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         req_q    <= req_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         memout_q <= memout_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   // Next-state sequencing: pointer phase, one-cycle strobe gap, data phase.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (mem_valid) state_d = mem_type[0] ? S_PTR : S_ACCESS;
         S_PTR: begin
            if (complete_data)    state_d = S_GAP;
            else if (timeout_hit) state_d = S_DONE;
         end
         S_GAP:    state_d = S_ACCESS;
         S_ACCESS: if (complete_data || timeout_hit) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      write_d = accept ? mem_type[1] : write_q;
      din_d   = accept ? M_data : din_q;

      addr_d = addr_q;
      if (accept)
         addr_d = M_addr;
      else if ((state_q == S_PTR) && complete_data)
         addr_d = Data_dout;  // pointer becomes the data-phase address

      req_d   = (state_d == S_PTR) || (state_d == S_ACCESS);
      rd_d    = !((state_d == S_ACCESS) && write_d);
      done_d  = (state_d == S_DONE);
      ready_d = (state_d == S_IDLE);

      // Counts stalled strobe cycles; drops to zero whenever no strobe is
      // stalling, so each phase starts from zero.
      cnt_d = '0;
      if (req_q && !complete_data && !timeout_hit)
         cnt_d = cnt_q + CNT_W'(1);

      memout_d = memout_q;
      if ((state_q == S_ACCESS) && complete_data && !write_q)
         memout_d = Data_dout;
      else if (timeout_hit)
         memout_d = '0;

      err_d = err_q;
      if (accept)
         err_d = 1'b0;
      else if (timeout_hit)
         err_d = 1'b1;
   end

   assign mem_ready = ready_q;
   assign Data_addr = addr_q;
   assign Data_din  = din_q;
   assign Data_rd   = rd_q;
   assign Data_req  = req_q;
   assign memout    = memout_q;
   assign mem_done  = done_q;
   assign mem_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_access
// Brief    : Scoreboard bench for lc3_mem_access: a memory responder with
//            per-strobe wait/hang control, a word-level reference model, and
//            a done-pulse monitor that checks result, error and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_access;

   localparam int TMO = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid;
   logic        mem_ready;
   logic [1:0]  mem_type;
   logic [15:0] M_addr, M_data;
   logic [15:0] Data_addr, Data_din, Data_dout;
   logic        Data_rd, Data_req, complete_data;
   logic [15:0] memout;
   logic        mem_done, mem_err;

   lc3_mem_access #(.DATA_W(16), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_type(mem_type),
      .M_addr(M_addr), .M_data(M_data),
      .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd),
      .Data_req(Data_req), .Data_dout(Data_dout), .complete_data(complete_data),
      .memout(memout), .mem_done(mem_done), .mem_err(mem_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] addr;
      logic        rd;
      logic [15:0] din;
      int          wt;
      bit          hang;
   } strb_t;

   typedef struct {
      logic [15:0] memout;
      logic        err;
      int          lat;
      int          t0;
   } exp_t;

   strb_t stq[$];
   exp_t  sbq[$];

   logic [15:0] mem_arr [0:65535];   // what the responder serves
   logic [15:0] ref_mem [0:65535];   // reference model's view of memory
   logic [15:0] exp_memout;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic setmem(input logic [15:0] a, input logic [15:0] v);
      mem_arr[a] = v;
      ref_mem[a] = v;
   endtask

   // Memory responder: checks each strobe against the expected strobe queue.
   strb_t       cur;
   int          scnt;
   logic [15:0] saddr, sdin;
   logic        srd;
   initial begin
      complete_data = 1'b0;
      Data_dout     = '0;
      scnt          = 0;
      cur           = '{addr: 16'h0, rd: 1'b1, din: 16'h0, wt: 0, hang: 1'b0};
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            scnt          = 0;
            complete_data = 1'b0;
         end else if (Data_req) begin
            if (scnt == 0) begin
               if (stq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_strobe: got addr %h expected no strobe", Data_addr);
                  cur = '{addr: Data_addr, rd: Data_rd, din: Data_din, wt: 0, hang: 1'b1};
               end else begin
                  cur = stq.pop_front();
                  check("strobe_addr", Data_addr, cur.addr);
                  check("strobe_rd", Data_rd, cur.rd);
                  if (!cur.rd) check("strobe_din", Data_din, cur.din);
               end
               saddr = Data_addr;
               srd   = Data_rd;
               sdin  = Data_din;
            end else begin
               check("stable_addr", Data_addr, saddr);
               check("stable_rd", Data_rd, srd);
               check("stable_din", Data_din, sdin);
            end
            scnt++;
            if (!cur.hang && scnt > cur.wt) begin
               complete_data = 1'b1;
               Data_dout     = mem_arr[Data_addr];
               if (!Data_rd) mem_arr[Data_addr] = Data_din;
            end else begin
               complete_data = 1'b0;
               Data_dout     = 16'($urandom);
            end
         end else begin
            if (scnt > 0) check("strobe_len", scnt, cur.hang ? TMO : cur.wt + 1);
            scnt = 0;
            // Noise while no strobe is active; the stage must ignore it.
            complete_data = 1'($urandom_range(0, 1));
            Data_dout     = 16'($urandom);
         end
      end
   end

   // Monitor: every done pulse is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && mem_done) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got mem_done=1 expected no pending request");
            end else begin
               e = sbq.pop_front();
               check("memout", memout, e.memout);
               check("mem_err", mem_err, e.err);
               check("latency", cyc - e.t0, e.lat);
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!mem_ready && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (!mem_ready) begin
         total++;
         bad++;
         $display("FAIL ready_wait: got mem_ready=0 for 300 cycles expected 1");
      end
   endtask

   // Reference model: word-level effect of one request. hph: 1 = pointer
   // phase never completes, 2 = data phase never completes (direct: any != 0).
   task automatic issue(input logic [1:0] ty, input logic [15:0] a, input logic [15:0] d,
                        input int wp, input int wa, input int hph);
      strb_t       s;
      exp_t        e;
      logic [15:0] fa;
      bit          err;
      int          lat;
      wait_ready();
      err = 1'b0;
      lat = 1;
      fa  = a;
      if (ty[0]) begin
         s = '{addr: a, rd: 1'b1, din: 16'h0, wt: wp, hang: (hph == 1)};
         stq.push_back(s);
         if (hph == 1) begin
            err = 1'b1;
            lat += TMO;
         end else begin
            fa  = ref_mem[a];
            lat += wp + 2;
         end
      end
      if (!err) begin
         s = '{addr: fa, rd: !ty[1], din: d, wt: wa, hang: ty[0] ? (hph == 2) : (hph != 0)};
         stq.push_back(s);
         if (s.hang) begin
            err = 1'b1;
            lat += TMO;
         end else begin
            lat += wa + 1;
            if (ty[1]) ref_mem[fa] = d;
            else       exp_memout  = ref_mem[fa];
         end
      end
      if (err) exp_memout = 16'h0;
      e = '{memout: exp_memout, err: err, lat: lat, t0: cyc};
      sbq.push_back(e);
      mem_valid = 1'b1;
      mem_type  = ty;
      M_addr    = a;
      M_data    = d;
      @(posedge clock);
      @(negedge clock);
      check("ready_busy", mem_ready, 1'b0);
      // Junk request while busy; it must never be serviced.
      mem_valid = 1'($urandom_range(0, 1));
      mem_type  = 2'($urandom);
      M_addr    = 16'($urandom);
      M_data    = 16'($urandom);
      @(negedge clock);
      mem_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] v;
      int          hph;
      logic [1:0]  ty;
      int          n;
      for (int i = 0; i < 65536; i++) begin
         v = 16'($urandom);
         mem_arr[i] = v;
         ref_mem[i] = v;
      end
      mem_valid  = 1'b0;
      mem_type   = 2'b00;
      M_addr     = '0;
      M_data     = '0;
      exp_memout = '0;
      reset      = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_req", Data_req, 1'b0);
      check("rst_rd", Data_rd, 1'b1);
      check("rst_addr", Data_addr, 16'h0);
      check("rst_din", Data_din, 16'h0);
      check("rst_memout", memout, 16'h0);
      check("rst_done", mem_done, 1'b0);
      check("rst_err", mem_err, 1'b0);
      check("rst_ready", mem_ready, 1'b1);
      reset = 1'b0;
      @(negedge clock);

      // Directed cases
      setmem(16'h3000, 16'hABCD);
      issue(2'b00, 16'h3000, 16'h0, 0, 0, 0);       // LD zero wait
      issue(2'b10, 16'h3010, 16'h1234, 0, 3, 0);    // ST, 3 wait cycles
      setmem(16'h3020, 16'h4000);
      setmem(16'h4000, 16'h00FF);
      issue(2'b01, 16'h3020, 16'h0, 0, 0, 0);       // LDI
      setmem(16'hFFFF, 16'h0005);
      issue(2'b11, 16'hFFFF, 16'h7777, 0, 0, 0);    // STI through FFFF
      issue(2'b00, 16'h0005, 16'h0, 0, 0, 0);       // read back STI target
      issue(2'b00, 16'h3000, 16'h0, 0, 0, 2);       // LD timeout
      issue(2'b00, 16'h3000, 16'h0, 0, TMO - 1, 0); // completes on last cycle
      issue(2'b01, 16'h3020, 16'h0, 0, 0, 1);       // LDI pointer timeout
      issue(2'b11, 16'h3020, 16'h5555, 2, 0, 2);    // STI data-phase timeout
      issue(2'b01, 16'h3020, 16'h0, 1, 2, 0);       // LDI after error clears

      // Reset in the middle of an indirect pointer read
      issue(2'b01, 16'h3020, 16'h0, 5, 0, 0);
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      check("midrst_req", Data_req, 1'b0);
      check("midrst_ready", mem_ready, 1'b1);
      check("midrst_done", mem_done, 1'b0);
      check("midrst_memout", memout, 16'h0);
      sbq.delete();
      stq.delete();
      exp_memout = 16'h0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      issue(2'b00, 16'h3000, 16'h0, 0, 0, 0);

      // Randomised traffic
      for (int k = 0; k < 150; k++) begin
         ty  = 2'($urandom);
         hph = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
         v   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         issue(ty, v, 16'($urandom), $urandom_range(0, TMO - 1),
               $urandom_range(0, TMO - 1), hph);
      end

      n = 0;
      while (sbq.size() != 0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending results expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
